// File: rtl/deglitch_multi.sv
// Multi-channel input deglitcher: 2-FF synchroniser plus per-channel rise/fall qualification counter.
// Optional per-channel glitch counters are built when DEGLITCH_MULTI_GLITCH_CNT_EN is defined.
module deglitch_multi #(
  parameter int CHANNELS      = 4,
  parameter int RISE_COUNT    = 1,
  parameter int FALL_COUNT    = 1,
  parameter int COUNTER_WIDTH = $clog2(((RISE_COUNT > FALL_COUNT) ? RISE_COUNT : FALL_COUNT) + 1),
  parameter logic [CHANNELS-1:0] DEFAULT_LOGIC = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    sample_en,
  input  logic [CHANNELS-1:0]     in,
  output logic [CHANNELS-1:0]     out,
  output logic [CHANNELS-1:0]     rise,
  output logic [CHANNELS-1:0]     fall,
  input  logic                    glitch_clear,
  output logic [8*CHANNELS-1:0]   glitch_count
);

  localparam int MAX_COUNT = (RISE_COUNT > FALL_COUNT) ? RISE_COUNT : FALL_COUNT;

  generate
    if (CHANNELS < 1) begin : g_bad_channels
      $error("deglitch_multi: CHANNELS must be >= 1");
    end
    if (RISE_COUNT < 1 || FALL_COUNT < 1) begin : g_bad_count
      $error("deglitch_multi: RISE_COUNT and FALL_COUNT must be >= 1");
    end
    if (COUNTER_WIDTH < 1 || ((MAX_COUNT - 1) >> COUNTER_WIDTH) != 0) begin : g_bad_width
      $error("deglitch_multi: COUNTER_WIDTH too small for the thresholds");
    end
  endgenerate

  localparam logic [COUNTER_WIDTH-1:0] RISE_LAST = COUNTER_WIDTH'(RISE_COUNT - 1);
  localparam logic [COUNTER_WIDTH-1:0] FALL_LAST = COUNTER_WIDTH'(FALL_COUNT - 1);

  logic [CHANNELS-1:0]      sync1_q, sync2_q, out_q, rise_q, fall_q;
  logic [CHANNELS-1:0]      out_d, rise_d, fall_d, abort_d;
  logic [COUNTER_WIDTH-1:0] cnt_q [CHANNELS];
  logic [COUNTER_WIDTH-1:0] cnt_d [CHANNELS];

  // abort_d marks a partial qualification thrown away because the input returned to the out level.
  always_comb begin
    logic [COUNTER_WIDTH-1:0] last;
    out_d   = out_q;
    rise_d  = '0;
    fall_d  = '0;
    abort_d = '0;
    last    = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      cnt_d[ch] = cnt_q[ch];
      last      = out_q[ch] ? FALL_LAST : RISE_LAST;
      if (sync2_q[ch] == out_q[ch]) begin
        cnt_d[ch]   = '0;
        abort_d[ch] = (cnt_q[ch] != '0);
      end else if (sample_en) begin
        if (cnt_q[ch] == last) begin
          out_d[ch]  = ~out_q[ch];
          cnt_d[ch]  = '0;
          rise_d[ch] = ~out_q[ch];
          fall_d[ch] = out_q[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= DEFAULT_LOGIC;
      sync2_q <= DEFAULT_LOGIC;
      out_q   <= DEFAULT_LOGIC;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        cnt_q[ch] <= '0;
      end
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        cnt_q[ch] <= cnt_d[ch];
      end
    end
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;

`ifdef DEGLITCH_MULTI_GLITCH_CNT_EN
  logic [7:0] glitch_q [CHANNELS];

  // Clear wins over a same-cycle increment; counters stick at 255.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        glitch_q[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        if (glitch_clear) begin
          glitch_q[ch] <= '0;
        end else if (abort_d[ch] && glitch_q[ch] != 8'hFF) begin
          glitch_q[ch] <= glitch_q[ch] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    glitch_count = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      glitch_count[8*ch +: 8] = glitch_q[ch];
    end
  end
`else
  logic unused_glitch;
  assign unused_glitch = ^{glitch_clear, abort_d};
  assign glitch_count  = '0;
`endif

endmodule
